// File: rtl/seven_seg_ndigit.sv
// Time-multiplexed N-digit seven-segment driver: frame-shadowed content, anti-ghosting dead time,
// 16-level PWM brightness. Optional leading-zero blanking is enabled by SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_ndigit #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 16384,
    parameter int BLANK_CYCLES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   seg_an,
    output logic [7:0]              seg_cat,
    output logic                    frame_start
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SW-1:0]         SLOT_LAST = SW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0]         BLANK_END = SW'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            CAT_OFF   = {8{ACTIVE_LOW}};

    // Hex nibble to logical-on segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [SW-1:0]           slot_cnt_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] shadow_value_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [NUM_DIGITS-1:0]   shadow_en_r;
    logic                    frame_start_r;
    logic [NUM_DIGITS-1:0]   seg_an_r;
    logic [7:0]              seg_cat_r;

    logic                    load_s;
    logic                    slot_wrap_s;
    logic [NUM_DIGITS-1:0]   show_s;
    logic [3:0]              nibble_s;
    logic                    dp_sel_s;
    logic                    show_sel_s;
    logic                    blank_s;
    logic                    duty_s;
    logic                    an_on_s;
    logic [NUM_DIGITS-1:0]   an_log_s;
    logic [7:0]              cat_log_s;

    assign load_s      = (slot_cnt_r == {SW{1'b0}}) && (idx_r == {IW{1'b0}});
    assign slot_wrap_s = (slot_cnt_r == SLOT_LAST);

    // Slot counter and digit index; the index advances once per full slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_r <= {SW{1'b0}};
            idx_r      <= {IW{1'b0}};
        end else if (slot_wrap_s) begin
            slot_cnt_r <= {SW{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_r <= {IW{1'b0}};
            end else begin
                idx_r <= idx_r + 1'b1;
            end
        end else begin
            slot_cnt_r <= slot_cnt_r + 1'b1;
        end
    end

    // Shadow capture at the frame boundary so a frame never shows mixed content.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r    <= {NUM_DIGITS{1'b0}};
            shadow_en_r    <= {NUM_DIGITS{1'b0}};
            frame_start_r  <= 1'b0;
        end else begin
            frame_start_r <= load_s;
            if (load_s) begin
                shadow_value_r <= value;
                shadow_dp_r    <= dp;
                shadow_en_r    <= digit_en;
            end else begin
                shadow_value_r <= shadow_value_r;
                shadow_dp_r    <= shadow_dp_r;
                shadow_en_r    <= shadow_en_r;
            end
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic higher_nz_s;

    // A digit survives if it or any more-significant nibble is nonzero; digit 0 and dp digits always do.
    always_comb begin
        show_s      = {NUM_DIGITS{1'b0}};
        higher_nz_s = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_nz_s = higher_nz_s | (shadow_value_r[4*i +: 4] != 4'h0);
            if (i == 0) begin
                show_s[i] = shadow_en_r[i];
            end else begin
                show_s[i] = shadow_en_r[i] & (higher_nz_s | shadow_dp_r[i]);
            end
        end
    end
`else
    // Every enabled digit is shown, leading zeros included.
    always_comb begin
        show_s = shadow_en_r;
    end
`endif

    // Select the current digit's nibble, dp and enable as an AND-OR mux.
    always_comb begin
        nibble_s   = 4'h0;
        dp_sel_s   = 1'b0;
        show_sel_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nibble_s   = nibble_s   | (shadow_value_r[4*i +: 4] & {4{idx_r == IW'(i)}});
            dp_sel_s   = dp_sel_s   | (shadow_dp_r[i] & (idx_r == IW'(i)));
            show_sel_s = show_sel_s | (show_s[i] & (idx_r == IW'(i)));
        end
    end

    // Logical-on anode/cathode pattern for the current slot; brightness is taken live.
    always_comb begin
        blank_s  = (slot_cnt_r < BLANK_END);
        duty_s   = (slot_cnt_r[3:0] <= brightness);
        an_on_s  = !blank_s && duty_s && show_sel_s;
        an_log_s = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_log_s[i] = an_on_s && (idx_r == IW'(i));
        end
        if (blank_s) begin
            cat_log_s = 8'h00;
        end else begin
            cat_log_s = {dp_sel_s, decode_hex(nibble_s)};
        end
    end

    // Output registers, converted to the pad polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_an_r  <= AN_OFF;
            seg_cat_r <= CAT_OFF;
        end else begin
            seg_an_r  <= an_log_s ^ AN_OFF;
            seg_cat_r <= cat_log_s ^ CAT_OFF;
        end
    end

    assign seg_an      = seg_an_r;
    assign seg_cat     = seg_cat_r;
    assign frame_start = frame_start_r;

endmodule
